// File: rtl/urisc_subleq_core.sv
// urisc_subleq_core: sequencer for a single-instruction (SUBLEQ) machine.
// Each instruction word holds A in [19:0], B in [39:20] and C in [59:40]. Bits
// [63:60] are ignored. The core computes mem[B] <= mem[B] - mem[A]. It branches
// to C when the result is <= 0, otherwise it goes to PC+1. A taken branch to
// HALT_ADDR stops the core.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, start_pc   one-cycle start pulse and initial PC (used when idle/halted)
//   mem_req/we/addr/wdata  shared memory port request, held until mem_ack
//   mem_rdata, mem_ack     read data and one-cycle completion strobe
//   busy, halted, pc       run status and current instruction address
//   retired           instructions retired (only when URISC_PERF_EN is defined)
//
// Optional feature macro: URISC_PERF_EN adds the saturating 32-bit retired counter.
module urisc_subleq_core #(
    parameter int unsigned       WORD_SIZE = 64,
    parameter int unsigned       ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_pc,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
`ifdef URISC_PERF_EN
    output logic [31:0]          retired,
`endif
    output logic                 busy,
    output logic                 halted,
    output logic [ADDR_W-1:0]    pc
);

    localparam int unsigned A_LSB = 0;
    localparam int unsigned B_LSB = ADDR_W;
    localparam int unsigned C_LSB = 2 * ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        RD_A  = 3'd2,
        RD_B  = 3'd3,
        WR_B  = 3'd4,
        NEXT  = 3'd5,
        HALT  = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [ADDR_W-1:0]      b_q, b_d;
    logic [ADDR_W-1:0]      c_q, c_d;
    logic [WORD_SIZE-1:0]   opa_q, opa_d;
    logic [WORD_SIZE-1:0]   res_q, res_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic                   busy_q, busy_d;
    logic                   halted_q, halted_d;
`ifdef URISC_PERF_EN
    logic [31:0]            retired_q, retired_d;
`endif

    logic                   accept;
    logic                   take;
    logic [ADDR_W-1:0]      target;

    // Acks only count while a request is outstanding.
    assign accept = req_q & mem_ack;
    // Signed result <= 0: sign bit set or all zero.
    assign take   = res_q[WORD_SIZE-1] | (res_q == '0);
    assign target = take ? c_q : pc_q + ADDR_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        b_d      = b_q;
        c_d      = c_q;
        opa_d    = opa_q;
        res_d    = res_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        halted_d = halted_q;
`ifdef URISC_PERF_EN
        retired_d = retired_q;
`endif
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d  = FETCH;
                    pc_d     = start_pc;
                    halted_d = 1'b0;
                    busy_d   = 1'b1;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = start_pc;
`ifdef URISC_PERF_EN
                    retired_d = '0;
`endif
                end
            end
            FETCH: begin
                if (accept) begin
                    state_d = RD_A;
                    b_d     = mem_rdata[B_LSB +: ADDR_W];
                    c_d     = mem_rdata[C_LSB +: ADDR_W];
                    addr_d  = mem_rdata[A_LSB +: ADDR_W];
                end
            end
            RD_A: begin
                if (accept) begin
                    state_d = RD_B;
                    opa_d   = mem_rdata;
                    addr_d  = b_q;
                end
            end
            RD_B: begin
                // opB feeds the subtraction directly; only the result is kept.
                if (accept) begin
                    state_d = WR_B;
                    we_d    = 1'b1;
                    addr_d  = b_q;
                    res_d   = mem_rdata - opa_q;
                    wdata_d = mem_rdata - opa_q;
                end
            end
            WR_B: begin
                if (accept) begin
                    state_d = NEXT;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            NEXT: begin
`ifdef URISC_PERF_EN
                if (retired_q != '1) begin
                    retired_d = retired_q + 32'd1;
                end
`endif
                if (take && (c_q == HALT_ADDR)) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    state_d = FETCH;
                    pc_d    = target;
                    req_d   = 1'b1;
                    addr_d  = target;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            b_q      <= '0;
            c_q      <= '0;
            opa_q    <= '0;
            res_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef URISC_PERF_EN
            retired_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            b_q      <= b_d;
            c_q      <= c_d;
            opa_q    <= opa_d;
            res_q    <= res_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
`ifdef URISC_PERF_EN
            retired_q <= retired_d;
`endif
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign pc        = pc_q;
`ifdef URISC_PERF_EN
    assign retired   = retired_q;
`endif

endmodule

// File: tb/tb_urisc_subleq_core.sv
// Testbench for urisc_subleq_core: a memory responder with optional wait states
// and spurious acks, plus a SUBLEQ interpreter used as the reference model.
module tb_urisc_subleq_core;

    localparam logic [19:0] HALT = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [19:0] start_pc;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        halted;
    logic [19:0] pc;
`ifdef URISC_PERF_EN
    logic [31:0] retired;
`endif

    always #5 clk = ~clk;

    urisc_subleq_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_pc  (start_pc),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
`ifdef URISC_PERF_EN
        .retired   (retired),
`endif
        .busy      (busy),
        .halted    (halted),
        .pc        (pc)
    );

    int errors = 0;
    int checks = 0;

    // Memory seen by the DUT (address taken mod 256) and the model's copy.
    logic [63:0] mem  [256];
    logic [63:0] rmem [256];

    // Responder controls and observations.
    bit          hold_ack = 1'b0;
    bit          spur_en  = 1'b0;
    int          max_dly  = 0;
    bit          in_acc   = 1'b0;
    int          dly      = 0;
    logic [19:0] s_addr;
    logic        s_we;
    logic [63:0] s_wdata;
    int          stab_err = 0;
    logic [19:0] wq_addr [$];
    logic [63:0] wq_data [$];

    // Reference results.
    logic [19:0] m_pc;
    bit          m_halt;
    int          m_n;
    logic [19:0] m_wa [$];
    logic [63:0] m_wd [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [19:0] c, input logic [19:0] b,
                                       input logic [19:0] a);
        return {4'h0, c, b, a};
    endfunction

    // Memory responder: random latency, write capture, stability monitoring.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (!mem_req) in_acc = 1'b0;
            if (mem_req && !hold_ack) begin
                if (!in_acc) begin
                    in_acc  = 1'b1;
                    dly     = int'($urandom_range(max_dly, 0));
                    s_addr  = mem_addr;
                    s_we    = mem_we;
                    s_wdata = mem_wdata;
                end else if (mem_addr !== s_addr || mem_we !== s_we ||
                             (s_we && mem_wdata !== s_wdata)) begin
                    stab_err++;
                end
                if (dly == 0) begin
                    mem_ack = 1'b1;
                    in_acc  = 1'b0;
                    if (mem_we) begin
                        mem[mem_addr[7:0]] = mem_wdata;
                        wq_addr.push_back(mem_addr);
                        wq_data.push_back(mem_wdata);
                    end else begin
                        mem_rdata = mem[mem_addr[7:0]];
                    end
                end else begin
                    dly--;
                end
            end else if (!mem_req && spur_en && $urandom_range(3, 0) == 0) begin
                mem_ack = 1'b1;
            end
        end
    end

    // Plain SUBLEQ interpreter over rmem.
    task automatic run_model(input logic [19:0] spc);
        logic [63:0] w, r;
        logic [19:0] a, b, c, p;
        m_wa.delete();
        m_wd.delete();
        m_n    = 0;
        m_halt = 1'b0;
        p      = spc;
        for (int k = 0; k < 1000 && !m_halt; k++) begin
            w = rmem[p[7:0]];
            a = w[19:0];
            b = w[39:20];
            c = w[59:40];
            r = rmem[b[7:0]] - rmem[a[7:0]];
            rmem[b[7:0]] = r;
            m_wa.push_back(b);
            m_wd.push_back(r);
            m_n++;
            if ($signed(r) <= 0) begin
                if (c == HALT) m_halt = 1'b1;
                else p = c;
            end else begin
                p = p + 20'd1;
            end
        end
        m_pc = p;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Run the program in mem from spc on both model and DUT, then compare.
    task automatic run_dut(input string tag, input logic [19:0] spc, input bit chk_cyc);
        int cyc;
        int d;
        int nw;
        for (int i = 0; i < 256; i++) rmem[i] = mem[i];
        run_model(spc);
        wq_addr.delete();
        wq_data.delete();
        stab_err = 0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        start_pc = spc;
        @(posedge clk);
        #1;
        start    = 1'b0;
        start_pc = 20'($urandom);
        chk({tag, "_start_halted"}, 64'(halted), 64'd0);
        chk({tag, "_start_busy"}, 64'(busy), 64'd1);
`ifdef URISC_PERF_EN
        chk({tag, "_start_retired"}, 64'(retired), 64'd0);
`endif
        cyc = 0;
        while (!halted && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            // A start pulse while busy must be ignored.
            if (!halted && cyc == 7) begin
                start    = 1'b1;
                start_pc = 20'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_model_halts"}, 64'(m_halt), 64'd1);
        chk({tag, "_halted"}, 64'(halted), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pc"}, 64'(pc), 64'(m_pc));
        chk({tag, "_nwrites"}, 64'(wq_addr.size()), 64'(m_wa.size()));
        nw = (wq_addr.size() < m_wa.size()) ? wq_addr.size() : m_wa.size();
        d = 0;
        for (int k = 0; k < nw; k++) begin
            if (wq_addr[k] !== m_wa[k] || wq_data[k] !== m_wd[k]) d++;
        end
        chk({tag, "_write_seq"}, 64'(d), 64'd0);
        d = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== rmem[i]) d++;
        chk({tag, "_mem"}, 64'(d), 64'd0);
        chk({tag, "_stable"}, 64'(stab_err), 64'd0);
        if (chk_cyc) chk({tag, "_cycles"}, 64'(cyc), 64'(5 * m_n));
`ifdef URISC_PERF_EN
        chk({tag, "_retired"}, 64'(retired), 64'(m_n));
`endif
    endtask

    initial begin
        int cnt;
        int n;
        logic [19:0] c;
        rst_n    = 1'b0;
        start    = 1'b0;
        start_pc = '0;
        clear_mem();

        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        #3 rst_n = 1'b1;

        // Reset in the middle of a fetch.
        hold_ack = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b1;
        start_pc = 20'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        while (!mem_req && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("fetch_req", 64'(mem_req), 64'd1);
        chk("fetch_addr", 64'(mem_addr), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", 64'(mem_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_pc", 64'(pc), 64'd0);
        #3 rst_n = 1'b1;
        hold_ack = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) cnt++;
        end
        chk("idle_req_cycles", 64'(cnt), 64'd0);

        // Positive result: write 4 to 11, fall through to 1, halt there.
        clear_mem();
        mem[0]  = mk(20'd5, 20'd11, 20'd10);
        mem[1]  = mk(HALT, 20'd20, 20'd20);
        mem[10] = 64'd3;
        mem[11] = 64'd7;
        mem[20] = 64'd9;
        run_dut("pos", 20'd0, 1'b1);
        chk("pos_mem11", mem[11], 64'd4);
        chk("pos_pc_const", 64'(pc), 64'd1);

        // Zero result branches to 5, where the halt lives.
        clear_mem();
        mem[0]  = mk(20'd5, 20'd11, 20'd10);
        mem[5]  = mk(HALT, 20'd20, 20'd20);
        mem[10] = 64'd7;
        mem[11] = 64'd7;
        mem[20] = 64'd9;
        run_dut("zero", 20'd0, 1'b1);
        chk("zero_mem11", mem[11], 64'd0);
        chk("zero_mem20", mem[20], 64'd0);
        chk("zero_pc_const", 64'(pc), 64'd5);

        // Negative result; restart also clears halted.
        mem[0]  = mk(20'd5, 20'd11, 20'd10);
        mem[10] = 64'd7;
        mem[11] = 64'd2;
        run_dut("neg", 20'd0, 1'b1);
        chk("neg_mem11", mem[11], 64'hFFFF_FFFF_FFFF_FFFB);
        chk("neg_pc_const", 64'(pc), 64'd5);

        // Three retiring instructions plus the halt.
        clear_mem();
        mem[0]  = mk(20'd9, 20'd11, 20'd10);
        mem[1]  = mk(20'd9, 20'd12, 20'd10);
        mem[2]  = mk(20'd9, 20'd13, 20'd10);
        mem[3]  = mk(HALT, 20'd20, 20'd20);
        mem[10] = 64'd3;
        mem[11] = 64'd7;
        mem[12] = 64'd10;
        mem[13] = 64'd4;
        run_dut("four", 20'd0, 1'b1);
        chk("four_cycles_const", 64'(m_n), 64'd4);
`ifdef URISC_PERF_EN
        chk("four_retired_const", 64'(retired), 64'd4);
`endif

        // Self-modifying: instruction 0 rewrites instruction 1 into a halt.
        clear_mem();
        mem[0]  = mk(20'd1, 20'd1, 20'd50);
        mem[1]  = mk(HALT, 20'd60, 20'd60) + 64'd5;
        mem[50] = 64'd5;
        run_dut("selfmod", 20'd0, 1'b1);
        chk("selfmod_pc_const", 64'(pc), 64'd1);

        // PC wrap from 0xFFFFF to 0.
        clear_mem();
        mem[255] = mk(20'd3, 20'd11, 20'd10);
        mem[0]   = mk(HALT, 20'd20, 20'd20);
        mem[10]  = 64'd3;
        mem[11]  = 64'd7;
        run_dut("wrap", 20'hFFFFF, 1'b1);
        chk("wrap_pc_const", 64'(pc), 64'd0);

        // Positive case again under wait states and spurious acks.
        max_dly = 4;
        spur_en = 1'b1;
        clear_mem();
        mem[0]  = mk(20'd5, 20'd11, 20'd10);
        mem[1]  = mk(HALT, 20'd20, 20'd20);
        mem[10] = 64'd3;
        mem[11] = 64'd7;
        run_dut("pos_ws", 20'd0, 1'b0);
        chk("pos_ws_mem11", mem[11], 64'd4);

        // Random forward-branching programs; first three with zero wait.
        for (int t = 0; t < 6; t++) begin
            max_dly = (t < 3) ? 0 : 4;
            spur_en = (t >= 3);
            clear_mem();
            n = int'($urandom_range(10, 3));
            for (int i = 0; i < n - 1; i++) begin
                if ($urandom_range(4, 0) == 0) c = HALT;
                else c = 20'($urandom_range(n - 1, i + 1));
                mem[i] = mk(c, 20'(100 + $urandom_range(7, 0)), 20'(100 + $urandom_range(7, 0)));
            end
            mem[n - 1] = mk(HALT, 20'd200, 20'd200);
            for (int i = 100; i < 108; i++) begin
                mem[i] = ($urandom_range(1, 0) == 1) ? 64'($urandom_range(20, 0))
                                                    : {$urandom, $urandom};
            end
            run_dut($sformatf("rnd%0d", t), 20'd0, t < 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
